// File: rtl/vc_credit_tracker.sv
// vc_credit_tracker: per-port, per-VC downstream credit accounting and VC
// ownership tracking for a router output stage. Every (port, VC) holds an
// IDLE/ACTIVE/DRAINING state and a credit counter; protocol violations set a
// sticky per-port error flag and the offending event is dropped.
module vc_credit_tracker #(
  parameter int NUM_PORTS = 5,
  parameter int NUM_VCS   = 4,
  parameter int BUF_DEPTH = 4,
  localparam int VCW = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
  localparam int CW  = $clog2(BUF_DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             alloc_valid,
  input  logic [NUM_PORTS*VCW-1:0]         alloc_vc,
  input  logic [NUM_PORTS-1:0]             send_valid,
  input  logic [NUM_PORTS*VCW-1:0]         send_vc,
  input  logic [NUM_PORTS-1:0]             send_tail,
  input  logic [NUM_PORTS-1:0]             credit_valid,
  input  logic [NUM_PORTS*VCW-1:0]         credit_vc,
  output logic [NUM_PORTS*NUM_VCS-1:0]     vc_available,
  output logic [NUM_PORTS*NUM_VCS-1:0]     credit_nonzero,
  output logic [NUM_PORTS*NUM_VCS*CW-1:0]  credit_count,
  output logic [NUM_PORTS-1:0]             error
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    DRAINING = 2'd2
  } vc_state_t;

  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

  vc_state_t      state_q [NUM_PORTS][NUM_VCS];
  vc_state_t      state_d [NUM_PORTS][NUM_VCS];
  logic [CW-1:0]  cnt_q   [NUM_PORTS][NUM_VCS];
  logic [CW-1:0]  cnt_d   [NUM_PORTS][NUM_VCS];
  logic [NUM_PORTS-1:0] err_q, err_d;

  logic hit_alloc  [NUM_PORTS][NUM_VCS];
  logic hit_send   [NUM_PORTS][NUM_VCS];
  logic hit_credit [NUM_PORTS][NUM_VCS];
  logic send_ok    [NUM_PORTS][NUM_VCS];
  logic credit_ok  [NUM_PORTS][NUM_VCS];

  // Decode per-VC events and decide which of them are legal this cycle.
  // A send paired with a credit on the same VC nets to zero, so it is legal
  // even at count 0, and the credit is legal even at a full count.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        hit_alloc[p][v]  = alloc_valid[p]  && (alloc_vc[p*VCW +: VCW]  == VCW'(v));
        hit_send[p][v]   = send_valid[p]   && (send_vc[p*VCW +: VCW]   == VCW'(v));
        hit_credit[p][v] = credit_valid[p] && (credit_vc[p*VCW +: VCW] == VCW'(v));
        send_ok[p][v]    = hit_send[p][v] && (state_q[p][v] != IDLE) &&
                           ((cnt_q[p][v] != '0) || hit_credit[p][v]);
        credit_ok[p][v]  = hit_credit[p][v] && ((cnt_q[p][v] != FULL) || send_ok[p][v]);
      end
    end
  end

  // Next-state, counter and sticky error computation.
  always_comb begin
    err_d = err_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        state_d[p][v] = state_q[p][v];
        cnt_d[p][v]   = cnt_q[p][v];

        if (hit_send[p][v] && !send_ok[p][v])
          err_d[p] = 1'b1;
        if (hit_credit[p][v] && !credit_ok[p][v])
          err_d[p] = 1'b1;
        if (hit_alloc[p][v] && (state_q[p][v] != IDLE))
          err_d[p] = 1'b1;

        if (send_ok[p][v] && !credit_ok[p][v])
          cnt_d[p][v] = cnt_q[p][v] - CW'(1);
        else if (credit_ok[p][v] && !send_ok[p][v])
          cnt_d[p][v] = cnt_q[p][v] + CW'(1);

        case (state_q[p][v])
          IDLE:     if (hit_alloc[p][v]) state_d[p][v] = ACTIVE;
          ACTIVE:   if (send_ok[p][v] && send_tail[p]) state_d[p][v] = DRAINING;
          default:  state_d[p][v] = state_q[p][v];
        endcase

        // A draining VC (including one that just saw its tail) is released
        // once every credit is back.
        if ((state_d[p][v] == DRAINING) && (cnt_d[p][v] == FULL))
          state_d[p][v] = IDLE;
      end
    end
  end

  // State registers; reset returns every VC to IDLE with a full credit pool.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        for (int v = 0; v < NUM_VCS; v++) begin
          state_q[p][v] <= IDLE;
          cnt_q[p][v]   <= FULL;
        end
      end
    end else begin
      err_q <= err_d;
      for (int p = 0; p < NUM_PORTS; p++) begin
        for (int v = 0; v < NUM_VCS; v++) begin
          state_q[p][v] <= state_d[p][v];
          cnt_q[p][v]   <= cnt_d[p][v];
        end
      end
    end
  end

  // Outputs are pure decodes of the registered state.
  always_comb begin
    vc_available   = '0;
    credit_nonzero = '0;
    credit_count   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        vc_available[p*NUM_VCS + v]           = (state_q[p][v] == IDLE);
        credit_nonzero[p*NUM_VCS + v]         = (cnt_q[p][v] != '0);
        credit_count[(p*NUM_VCS + v)*CW +: CW] = cnt_q[p][v];
      end
    end
  end

  assign error = err_q;

endmodule

// File: tb/tb_vc_credit_tracker.sv
// tb_vc_credit_tracker: directed scenarios followed by randomized traffic,
// all outputs compared every cycle against a behavioural model of the
// credit/ownership rules.
module tb_vc_credit_tracker;

  localparam int NP  = 5;
  localparam int NV  = 4;
  localparam int BD  = 4;
  localparam int VCW = 2;
  localparam int CW  = 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NP-1:0]         alloc_valid, send_valid, send_tail, credit_valid;
  logic [NP*VCW-1:0]     alloc_vc, send_vc, credit_vc;
  logic [NP*NV-1:0]      vc_available, credit_nonzero;
  logic [NP*NV*CW-1:0]   credit_count;
  logic [NP-1:0]         error;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: 0 = idle, 1 = owned by a packet, 2 = tail sent, waiting for credits
  int m_st  [NP][NV];
  int m_cnt [NP][NV];
  bit m_err [NP];

  vc_credit_tracker #(.NUM_PORTS(NP), .NUM_VCS(NV), .BUF_DEPTH(BD)) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_vc(alloc_vc),
    .send_valid(send_valid), .send_vc(send_vc), .send_tail(send_tail),
    .credit_valid(credit_valid), .credit_vc(credit_vc),
    .vc_available(vc_available), .credit_nonzero(credit_nonzero),
    .credit_count(credit_count), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one clock of the protocol rules to the model.
  task automatic model_update();
    if (reset) begin
      for (int p = 0; p < NP; p++) begin
        m_err[p] = 0;
        for (int v = 0; v < NV; v++) begin
          m_st[p][v] = 0;
          m_cnt[p][v] = BD;
        end
      end
      return;
    end
    for (int p = 0; p < NP; p++) begin
      int av, sv, cv;
      av = int'(alloc_vc[p*VCW +: VCW]);
      sv = int'(send_vc[p*VCW +: VCW]);
      cv = int'(credit_vc[p*VCW +: VCW]);
      for (int v = 0; v < NV; v++) begin
        bit a, s, c, s_ok, c_ok;
        int ncnt, nst;
        a = alloc_valid[p] && (av == v);
        s = send_valid[p] && (sv == v);
        c = credit_valid[p] && (cv == v);
        // sends need an owned VC and a credit to spend (or one arriving now)
        s_ok = s && (m_st[p][v] != 0) && (m_cnt[p][v] > 0 || c);
        // credits must fit in the pool unless a flit leaves at the same time
        c_ok = c && (m_cnt[p][v] < BD || s_ok);
        if ((s && !s_ok) || (c && !c_ok) || (a && m_st[p][v] != 0)) m_err[p] = 1;
        ncnt = m_cnt[p][v] - int'(s_ok) + int'(c_ok);
        nst = m_st[p][v];
        if (m_st[p][v] == 0 && a) nst = 1;
        if (m_st[p][v] == 1 && s_ok && send_tail[p]) nst = 2;
        if (nst == 2 && ncnt == BD) nst = 0;
        m_cnt[p][v] = ncnt;
        m_st[p][v]  = nst;
      end
    end
  endtask

  task automatic compare_all();
    logic [NP*NV-1:0]    e_av, e_nz;
    logic [NP*NV*CW-1:0] e_cc;
    logic [NP-1:0]       e_er;
    for (int p = 0; p < NP; p++) begin
      e_er[p] = m_err[p];
      for (int v = 0; v < NV; v++) begin
        e_av[p*NV+v] = (m_st[p][v] == 0);
        e_nz[p*NV+v] = (m_cnt[p][v] != 0);
        e_cc[(p*NV+v)*CW +: CW] = CW'(m_cnt[p][v]);
      end
    end
    chk("vc_available", 64'(vc_available), 64'(e_av));
    chk("credit_nonzero", 64'(credit_nonzero), 64'(e_nz));
    chk("credit_count", 64'(credit_count), 64'(e_cc));
    chk("error", 64'(error), 64'(e_er));
  endtask

  task automatic clear_in();
    alloc_valid = '0; send_valid = '0; send_tail = '0; credit_valid = '0;
    alloc_vc = '0; send_vc = '0; credit_vc = '0;
  endtask

  task automatic do_alloc(input int p, input int v);
    alloc_valid[p] = 1'b1; alloc_vc[p*VCW +: VCW] = VCW'(v);
  endtask

  task automatic do_send(input int p, input int v, input bit tail);
    send_valid[p] = 1'b1; send_vc[p*VCW +: VCW] = VCW'(v); send_tail[p] = tail;
  endtask

  task automatic do_credit(input int p, input int v);
    credit_valid[p] = 1'b1; credit_vc[p*VCW +: VCW] = VCW'(v);
  endtask

  // One clock: model and DUT see the same inputs, outputs checked after the edge.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
    clear_in();
    reset = 1'b0;
  endtask

  function automatic logic [CW-1:0] cnt_of(input int p, input int v);
    logic [NP*NV*CW-1:0] tmp;
    tmp = credit_count;
    return tmp[(p*NV+v)*CW +: CW];
  endfunction

  initial begin
    clear_in();
    reset = 1'b1;
    for (int i = 0; i < NP; i++) m_err[i] = 0;
    step();
    reset = 1'b1;
    step();

    // post-reset values
    chk("rst_avail", 64'(vc_available), 64'(20'hFFFFF));
    chk("rst_nonzero", 64'(credit_nonzero), 64'(20'hFFFFF));
    chk("rst_cnt00", 64'(cnt_of(0, 0)), 64'(4));
    chk("rst_cnt43", 64'(cnt_of(4, 3)), 64'(4));
    chk("rst_error", 64'(error), 64'(0));

    // allocation of (0,2)
    do_alloc(0, 2); step();
    chk("alloc_avail", 64'(vc_available), 64'(20'hFFFFB));
    chk("alloc_cnt", 64'(cnt_of(0, 2)), 64'(4));

    // drain the pool of (0,2), then underflow
    for (int i = 0; i < 4; i++) begin
      do_send(0, 2, 1'b0); step();
      chk("send_cnt", 64'(cnt_of(0, 2)), 64'(3 - i));
    end
    chk("nonzero_bit2", 64'(credit_nonzero[2]), 64'(0));
    do_send(0, 2, 1'b0); step();
    chk("underflow_err0", 64'(error[0]), 64'(1));
    chk("underflow_cnt", 64'(cnt_of(0, 2)), 64'(0));

    // simultaneous send and credit on (1,0) at count 2
    do_alloc(1, 0); step();
    do_send(1, 0, 1'b0); step();
    do_send(1, 0, 1'b0); step();
    do_send(1, 0, 1'b0); do_credit(1, 0); step();
    chk("sendcred_cnt", 64'(cnt_of(1, 0)), 64'(2));
    chk("sendcred_err1", 64'(error[1]), 64'(0));

    // tail on (3,1) then credit return releases the VC
    do_alloc(3, 1); step();
    do_send(3, 1, 1'b1); step();
    chk("tail_cnt", 64'(cnt_of(3, 1)), 64'(3));
    chk("tail_avail13", 64'(vc_available[13]), 64'(0));
    do_credit(3, 1); step();
    chk("drain_cnt", 64'(cnt_of(3, 1)), 64'(4));
    chk("drain_avail13", 64'(vc_available[13]), 64'(1));

    // credit overflow on idle (4,3); double alloc on (2,0)
    do_credit(4, 3); step();
    chk("overflow_err4", 64'(error[4]), 64'(1));
    chk("overflow_cnt", 64'(cnt_of(4, 3)), 64'(4));
    do_alloc(2, 0); step();
    chk("alloc1_err2", 64'(error[2]), 64'(0));
    do_alloc(2, 0); step();
    chk("realloc_err2", 64'(error[2]), 64'(1));

    // reset while (0,1) drains with one credit left
    do_alloc(0, 1); step();
    for (int i = 0; i < 2; i++) begin do_send(0, 1, 1'b0); step(); end
    do_send(0, 1, 1'b1); step();
    chk("pre_rst_cnt01", 64'(cnt_of(0, 1)), 64'(1));
    chk("pre_rst_avail1", 64'(vc_available[1]), 64'(0));
    reset = 1'b1; step();
    chk("midrst_cnt01", 64'(cnt_of(0, 1)), 64'(4));
    chk("midrst_avail", 64'(vc_available), 64'(20'hFFFFF));
    chk("midrst_error", 64'(error), 64'(0));

    // randomized traffic against the model
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(3) == 0) do_alloc(p, int'($urandom_range(NV-1)));
        if ($urandom_range(1) == 0) do_send(p, int'($urandom_range(NV-1)), ($urandom_range(3) == 0));
        if ($urandom_range(7) < 3) do_credit(p, int'($urandom_range(NV-1)));
      end
      if ($urandom_range(79) == 0) reset = 1'b1;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vc_credit_tracker.md
VC_CREDIT_TRACKER -- requirements
Module: vc_credit_tracker

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 5: number of output ports tracked.
REQ-002 SHALL have parameter NUM_VCS, default 4: VCs per port; VCW = max(1, $clog2(NUM_VCS)).
REQ-003 SHALL have parameter BUF_DEPTH, default 4: downstream buffer slots (credits) per VC; CW = $clog2(BUF_DEPTH+1).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 alloc_valid  input  NUM_PORTS  per port: claim the downstream VC given by alloc_vc.
REQ-007 alloc_vc  input  NUM_PORTS*VCW  VC index; port p occupies bits [p*VCW +: VCW].
REQ-008 send_valid  input  NUM_PORTS  per port: one flit sent downstream, consuming one credit.
REQ-009 send_vc  input  NUM_PORTS*VCW  VC index of the sent flit; same packing as alloc_vc.
REQ-010 send_tail  input  NUM_PORTS  sent flit is a tail; qualified by send_valid.
REQ-011 credit_valid  input  NUM_PORTS  per port: one credit returned by the downstream router.
REQ-012 credit_vc  input  NUM_PORTS*VCW  VC index of the returned credit.
REQ-013 vc_available  output  NUM_PORTS*NUM_VCS  bit p*NUM_VCS+v = 1 when VC v of port p is IDLE.
REQ-014 credit_nonzero  output  NUM_PORTS*NUM_VCS  bit p*NUM_VCS+v = 1 when that VC's credit count > 0.
REQ-015 credit_count  output  NUM_PORTS*NUM_VCS*CW  count of VC (p,v) at bits [(p*NUM_VCS+v)*CW +: CW].
REQ-016 error  output  NUM_PORTS  sticky per-port protocol-violation flag.

Function
REQ-017 Each (port, VC) pair SHALL hold a 2-bit state {IDLE, ACTIVE, DRAINING} and a CW-bit credit counter.
REQ-018 All outputs SHALL be decoded directly from registered state; an input applied in cycle n is visible on outputs in cycle n+1.
REQ-019 IDLE -> ACTIVE on alloc_valid targeting the VC; the counter is not changed.
REQ-020 ACTIVE -> DRAINING on an accepted send with send_tail=1; a non-tail send leaves the state ACTIVE.
REQ-021 DRAINING -> IDLE in the cycle the next-state counter equals BUF_DEPTH (all credits returned).
REQ-022 An accepted send SHALL decrement the counter by 1; an accepted credit SHALL increment it by 1.
REQ-023 Send and credit on the same VC in the same cycle SHALL leave the counter unchanged, with no error.
REQ-024 A send with counter==0 (underflow), or a send to an IDLE VC, SHALL be dropped and SHALL set error[p].
REQ-025 A credit with counter==BUF_DEPTH and no same-cycle send on that VC (overflow) SHALL be dropped and SHALL set error[p].
REQ-026 An alloc to a non-IDLE VC SHALL be ignored and SHALL set error[p], including a VC whose DRAINING->IDLE transition occurs in the same cycle.
REQ-027 Ports SHALL operate independently; each port carries at most one alloc, one send and one credit per cycle, and the three may target different VCs.
REQ-028 Counter arithmetic SHALL never wrap; the counter stays within 0..BUF_DEPTH.
REQ-029 error bits SHALL remain set until reset.

Reset
REQ-030 While reset=1 at a rising edge, every VC SHALL become IDLE with counter=BUF_DEPTH and error SHALL clear; all inputs are ignored that cycle.
REQ-031 After reset, vc_available and credit_nonzero SHALL be all ones, every credit_count field SHALL equal BUF_DEPTH, and error SHALL be 0.
REQ-032 Reset asserted mid-packet SHALL discard all ACTIVE and DRAINING state, with no error raised.

Verification
REQ-033 Reset, then alloc (port 0, VC 2) -> next cycle vc_available bit 2 = 0, all other bits 1, credit_count(0,2)=4.
REQ-034 From ACTIVE (0,2): 4 non-tail sends on consecutive cycles -> counts 3,2,1,0; credit_nonzero bit 2 = 0; a 5th send is dropped and error[0]=1.
REQ-035 Simultaneous send and credit on (1,0) with count 2 -> count stays 2, error[1]=0.
REQ-036 Tail send on (3,1) with count 4 -> DRAINING, count 3; credit returned -> count 4 and vc_available bit 13 = 1 the following cycle.
REQ-037 Credit on IDLE (4,3) with count 4 -> dropped, error[4]=1; alloc on ACTIVE (2,0) -> ignored, error[2]=1.
REQ-038 Reset asserted while (0,1) is DRAINING with count 1 -> next cycle count 4, vc_available all ones, error all zeros.
